cv32e40p_str_op_issue: RTL and testbench

//  Initiator side of the string-op datapath interface (enable/operator/operand -> result).

---
 rtl/cv32e40p_str_op_issue.sv | 144 ++++++++++++++
 tb/tb_cv32e40p_str_op_issue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_str_op_issue.sv
// String-op issue unit: queues EX requests, drives the combinational str-ops
// datapath one request at a time and returns tagged results to writeback.
module cv32e40p_str_op_issue #(
  parameter int STR_OP_WIDTH = 2,
  parameter int FIFO_DEPTH   = 2,
  parameter int RESP_LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [STR_OP_WIDTH-1:0] req_operator_i,
  input  logic [31:0]             req_operand_i,
  input  logic [4:0]              req_rd_i,
  output logic                    str_enable_o,
  output logic [STR_OP_WIDTH-1:0] str_operator_o,
  output logic [31:0]             str_operand_o,
  input  logic [31:0]             str_result_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_result_o,
  output logic [4:0]              rsp_rd_o,
  output logic                    rsp_err_o,
  output logic                    busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  logic [STR_OP_WIDTH-1:0] fifo_op      [FIFO_DEPTH];
  logic [31:0]             fifo_operand [FIFO_DEPTH];
  logic [4:0]              fifo_rd      [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;

  state_e                  state;
  logic [LAT_W-1:0]        cnt;
  logic [STR_OP_WIDTH-1:0] ex_op;
  logic [31:0]             ex_operand;
  logic [4:0]              ex_rd;
  logic [31:0]             rsp_result_q;
  logic [4:0]              rsp_rd_q;
  logic                    rsp_err_q;

  logic                    push, pop, head_legal;
  logic [STR_OP_WIDTH-1:0] head_op;
  logic [31:0]             head_operand;
  logic [4:0]              head_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_op      = fifo_op[rd_ptr];
  assign head_operand = fifo_operand[rd_ptr];
  assign head_rd      = fifo_rd[rd_ptr];
  // Only the four base encodings are legal; wider operator fields add illegal codes.
  assign head_legal   = (32'(head_op) < 32'd4);

  // No push at full even with a simultaneous pop: keeps ready independent of FSM state.
  assign req_ready_o = rst_n && !flush_i && (count < CNT_W'(FIFO_DEPTH));
  assign push        = req_valid_i && req_ready_o;
  assign pop         = rst_n && !flush_i && (count != '0) &&
                       ((state == IDLE) || ((state == RESP) && rsp_ready_i));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]      <= req_operator_i;
      fifo_operand[wr_ptr] <= req_operand_i;
      fifo_rd[wr_ptr]      <= req_rd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      state        <= IDLE;
      cnt          <= '0;
      ex_op        <= '0;
      ex_operand   <= '0;
      ex_rd        <= '0;
      rsp_result_q <= '0;
      rsp_rd_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else if (pop) begin
      // pop only fires from IDLE or on a RESP handshake, so this covers both entry paths
      ex_op      <= head_op;
      ex_operand <= head_operand;
      ex_rd      <= head_rd;
      cnt        <= LAT_W'(RESP_LATENCY);
      if (head_legal) begin
        state <= EXEC;
      end else begin
        state        <= RESP;
        rsp_result_q <= head_operand;
        rsp_rd_q     <= head_rd;
        rsp_err_q    <= 1'b1;
      end
    end else begin
      case (state)
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result_q <= str_result_i;
            rsp_rd_q     <= ex_rd;
            rsp_err_q    <= 1'b0;
            state        <= RESP;
          end
        end
        RESP:    if (rsp_ready_i) state <= IDLE;
        default: ;
      endcase
    end
  end

  // Datapath inputs are forced to zero outside EXEC so the unit stays quiet.
  assign str_enable_o   = (state == EXEC);
  assign str_operator_o = str_enable_o ? ex_op : '0;
  assign str_operand_o  = str_enable_o ? ex_operand : '0;

  assign rsp_valid_o  = (state == RESP);
  assign rsp_result_o = rsp_valid_o ? rsp_result_q : '0;
  assign rsp_rd_o     = rsp_valid_o ? rsp_rd_q : '0;
  assign rsp_err_o    = rsp_valid_o && rsp_err_q;

  assign busy_o = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_cv32e40p_str_op_issue.sv
// Bench for cv32e40p_str_op_issue: a 3-bit-operator/zero-latency instance and a
// 2-bit/latency-2 instance, each checked every cycle against a queue model.
module tb_cv32e40p_str_op_issue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, flush, rsp_ready;
  logic [1:0][2:0]  req_op;
  logic [1:0][31:0] req_operand;
  logic [1:0][4:0]  req_rd;
  wire  [1:0]       req_ready, str_en, rsp_valid, rsp_err, busy;
  wire  [1:0][2:0]  str_op;
  wire  [1:0]       str_op_b;
  wire  [1:0][31:0] str_operand, str_result, rsp_result;
  wire  [1:0][4:0]  rsp_rd;

  int checks = 0;
  int failures = 0;
  int rsp_cnt[2];

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] operand;
    logic [4:0]  rd;
  } req_t;

  cv32e40p_str_op_issue #(.STR_OP_WIDTH(3), .FIFO_DEPTH(2), .RESP_LATENCY(0)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_operator_i(req_op[0]),
    .req_operand_i(req_operand[0]), .req_rd_i(req_rd[0]),
    .str_enable_o(str_en[0]), .str_operator_o(str_op[0]), .str_operand_o(str_operand[0]),
    .str_result_i(str_result[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_result_o(rsp_result[0]),
    .rsp_rd_o(rsp_rd[0]), .rsp_err_o(rsp_err[0]), .busy_o(busy[0]));

  cv32e40p_str_op_issue #(.STR_OP_WIDTH(2), .FIFO_DEPTH(2), .RESP_LATENCY(2)) u_dut_lat2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_operator_i(req_op[1][1:0]),
    .req_operand_i(req_operand[1]), .req_rd_i(req_rd[1]),
    .str_enable_o(str_en[1]), .str_operator_o(str_op_b), .str_operand_o(str_operand[1]),
    .str_result_i(str_result[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_result_o(rsp_result[1]),
    .rsp_rd_o(rsp_rd[1]), .rsp_err_o(rsp_err[1]), .busy_o(busy[1]));

  assign str_op[1] = {1'b0, str_op_b};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference string ops: 0 UPPER, 1 LOWER, 2 LEET, 3 ROT13.
  function automatic logic [31:0] str_f(input logic [2:0] op, input logic [31:0] x);
    logic [31:0] r;
    logic [7:0]  c;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      c = x[8*b +: 8];
      case (op)
        3'd0: begin if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20; end
        3'd1: begin if (c >= 8'h41 && c <= 8'h5a) c = c + 8'h20; end
        3'd2: begin
          if (c == 8'h61) c = 8'h34;
          else if (c == 8'h65) c = 8'h33;
          else if (c == 8'h6f) c = 8'h30;
        end
        3'd3: begin
          if (c >= 8'h61 && c <= 8'h7a) c = 8'h61 + ((c - 8'h61 + 8'd13) % 8'd26);
          else if (c >= 8'h41 && c <= 8'h5a) c = 8'h41 + ((c - 8'h41 + 8'd13) % 8'd26);
        end
        default: ;
      endcase
      r[8*b +: 8] = c;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int L = (g == 1) ? 2 : 0;
    req_t q[$];
    int   run = 0;
    bit   abort = 1'b0;

    // Latency-2 stub adds the enable-cycle index so an early or late sample is visible.
    assign str_result[g] = str_f(str_op[g], str_operand[g]) + ((g == 1) ? 32'(run) : 32'd0);

    function automatic logic [31:0] exp_res(input req_t e);
      if (e.op < 3'd4) return str_f(e.op, e.operand) + ((g == 1) ? 32'(L + 1) : 32'd0);
      return e.operand;
    endfunction

    always @(posedge clk) begin
      if (!rst_n || flush[g]) begin
        q.delete();
      end else begin
        if (rsp_valid[g] && rsp_ready[g]) begin
          rsp_cnt[g]++;
          if (q.size() != 0) void'(q.pop_front());
        end
        if (req_valid[g] && req_ready[g]) q.push_back({req_op[g], req_operand[g], req_rd[g]});
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        chk($sformatf("busy[%0d]", g), busy[g], q.size() != 0);
        if (str_en[g]) begin
          if (q.size() == 0) chk($sformatf("enable_without_req[%0d]", g), str_en[g], 1'b0);
          else begin
            chk($sformatf("str_operator[%0d]", g), str_op[g], q[0].op);
            chk($sformatf("str_operand[%0d]", g), str_operand[g], q[0].operand);
          end
          if (flush[g]) abort = 1'b1;
          run++;
        end else begin
          chk($sformatf("quiet_operator[%0d]", g), str_op[g], 32'd0);
          chk($sformatf("quiet_operand[%0d]", g), str_operand[g], 32'd0);
          if (run != 0) begin
            if (!abort) chk($sformatf("enable_len[%0d]", g), run, L + 1);
            run = 0;
            abort = 1'b0;
          end
        end
        if (rsp_valid[g]) begin
          if (q.size() == 0) chk($sformatf("rsp_without_req[%0d]", g), rsp_valid[g], 1'b0);
          else begin
            chk($sformatf("rsp_result[%0d]", g), rsp_result[g], exp_res(q[0]));
            chk($sformatf("rsp_rd[%0d]", g), rsp_rd[g], q[0].rd);
            chk($sformatf("rsp_err[%0d]", g), rsp_err[g], q[0].op >= 3'd4);
          end
        end
      end else if (run != 0) begin
        abort = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [2:0] op, input logic [31:0] d, input logic [4:0] rd);
    req_valid[i] = 1'b1;
    req_op[i] = op;
    req_operand[i] = d;
    req_rd[i] = rd;
  endtask

  task automatic wait_accept(input int i);
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
      else tick();
    end
    chk($sformatf("accept_timeout[%0d]", i), ok, 1'b1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [2:0] op, input logic [31:0] d, input logic [4:0] rd);
    drive(i, op, d, rd);
    wait_accept(i);
  endtask

  task automatic wait_idle(input int i);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!busy[i] && !rsp_valid[i]) ok = 1'b1;
    end
    chk($sformatf("idle_timeout[%0d]", i), ok, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    req_valid = '0; flush = '0; rsp_ready = 2'b11;
    req_op = '0; req_operand = '0; req_rd = '0;
    tick(); tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", req_ready[i], 1'b0);
      chk("reset_busy", busy[i], 1'b0);
      chk("reset_rsp_valid", rsp_valid[i], 1'b0);
      chk("reset_enable", str_en[i], 1'b0);
    end
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset0", req_ready[0], 1'b1);
    chk("ready_after_reset1", req_ready[1], 1'b1);

    // UPPER, latency 0: enable at N+2, response at N+3
    tick(); drive(0, 3'd0, 32'h61626364, 5'd7);
    @(negedge clk); chk("t1_ready", req_ready[0], 1'b1);
    tick(); req_valid[0] = 1'b0;
    @(negedge clk); chk("t1_no_enable_n1", str_en[0], 1'b0);
    tick();
    @(negedge clk);
    chk("t1_enable_n2", str_en[0], 1'b1);
    chk("t1_operand", str_operand[0], 32'h61626364);
    chk("t1_operator", str_op[0], 32'd0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid_n3", rsp_valid[0], 1'b1);
    chk("t1_rsp_result", rsp_result[0], 32'h41424344);
    chk("t1_rsp_rd", rsp_rd[0], 32'd7);
    chk("t1_rsp_err", rsp_err[0], 1'b0);
    tick();
    @(negedge clk);
    chk("t1_rsp_done", rsp_valid[0], 1'b0);
    chk("t1_not_busy", busy[0], 1'b0);

    // illegal operator goes straight to RESP with the operand echoed
    tick(); send(0, 3'd5, 32'hDEADBEEF, 5'd3);
    @(negedge clk); chk("t4_no_enable_a", str_en[0], 1'b0);
    tick();
    @(negedge clk);
    chk("t4_no_enable_b", str_en[0], 1'b0);
    chk("t4_rsp_valid", rsp_valid[0], 1'b1);
    chk("t4_rsp_result", rsp_result[0], 32'hDEADBEEF);
    chk("t4_rsp_err", rsp_err[0], 1'b1);
    chk("t4_rsp_rd", rsp_rd[0], 32'd3);
    wait_idle(0);

    // backpressure: one in RESP, two queued, fourth refused
    tick(); rsp_ready[0] = 1'b0; base = rsp_cnt[0];
    send(0, 3'd1, 32'h41424344, 5'd1);
    send(0, 3'd2, 32'h6c656574, 5'd2);
    send(0, 3'd3, 32'h4e4f5051, 5'd3);
    drive(0, 3'd0, 32'h7a7a7a7a, 5'd4);
    @(negedge clk);
    chk("t2_ready_full", req_ready[0], 1'b0);
    chk("t2_rsp_held", rsp_valid[0], 1'b1);
    chk("t2_first_result", rsp_result[0], 32'h61626364);
    tick(); tick(); rsp_ready[0] = 1'b1;
    wait_accept(0);
    wait_idle(0);
    chk("t2_rsp_count", rsp_cnt[0] - base, 32'd4);

    // latency 2, ROT13: three stable enable cycles, sampled on the third
    tick(); send(1, 3'd3, 32'h61626364, 5'd9);
    @(negedge clk); chk("t3_no_enable_n1", str_en[1], 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("t3_enable_%0d", k), str_en[1], 1'b1);
      chk($sformatf("t3_operator_%0d", k), str_op[1], 32'd3);
      chk($sformatf("t3_operand_%0d", k), str_operand[1], 32'h61626364);
    end
    tick();
    @(negedge clk);
    chk("t3_rsp_valid", rsp_valid[1], 1'b1);
    chk("t3_rsp_result", rsp_result[1], 32'h6e6f7074);
    chk("t3_rsp_rd", rsp_rd[1], 32'd9);
    wait_idle(1);

    // flush during EXEC with two queued; the request offered with flush is refused
    tick(); base = rsp_cnt[1];
    send(1, 3'd0, 32'h61626364, 5'd1);
    send(1, 3'd1, 32'h41424344, 5'd2);
    send(1, 3'd2, 32'h6c656574, 5'd3);
    flush[1] = 1'b1;
    drive(1, 3'd3, 32'h11111111, 5'd4);
    @(negedge clk);
    chk("t5_ready_in_flush", req_ready[1], 1'b0);
    chk("t5_exec_before_flush", str_en[1], 1'b1);
    tick(); flush[1] = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_enable_after", str_en[1], 1'b0);
    chk("t5_rsp_after", rsp_valid[1], 1'b0);
    chk("t5_busy_after", busy[1], 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk("t5_stays_idle", {busy[1], rsp_valid[1]}, 32'd0);
    end
    chk("t5_no_response", rsp_cnt[1] - base, 32'd0);

    // reset while a response is pending and the FIFO is non-empty
    tick(); rsp_ready[0] = 1'b0;
    send(0, 3'd0, 32'h61626364, 5'd1);
    send(0, 3'd1, 32'h41424344, 5'd2);
    send(0, 3'd2, 32'h6c656574, 5'd3);
    @(negedge clk);
    chk("t6_pre_rsp_valid", rsp_valid[0], 1'b1);
    chk("t6_pre_busy", busy[0], 1'b1);
    tick(); rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_req_ready", req_ready[0], 1'b0);
    chk("t6_enable", str_en[0], 1'b0);
    chk("t6_operator", str_op[0], 32'd0);
    chk("t6_operand", str_operand[0], 32'd0);
    chk("t6_rsp_valid", rsp_valid[0], 1'b0);
    chk("t6_rsp_result", rsp_result[0], 32'd0);
    chk("t6_rsp_rd", rsp_rd[0], 32'd0);
    chk("t6_rsp_err", rsp_err[0], 1'b0);
    chk("t6_busy", busy[0], 1'b0);
    tick(); rst_n = 1'b1; rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", req_ready[0], 1'b1);
    chk("t6_busy_after", busy[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("t6_no_stale_rsp", rsp_valid[0], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
